// File: rtl/systolic_stream_port_pkg.sv
// rtl/systolic_stream_port_pkg.sv - shared defaults and block indexing helper
package systolic_stream_port_pkg;

  localparam int DEF_DW    = 4;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_NCH   = 2;

  // Offset of beat k of channel c inside a flattened block of dw-bit elements.
  function automatic int blk_off(input int c, input int k, input int depth, input int dw);
    return (c * depth + k) * dw;
  endfunction

endpackage

// File: rtl/systolic_stream_port_if.sv
// rtl/systolic_stream_port_if.sv - result block handshake from the compute core
interface systolic_stream_port_if
  import systolic_stream_port_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NCH   = DEF_NCH
) ();

  logic [NCH*DEPTH*DW-1:0] res_data;
  logic [NCH*DEPTH-1:0]    res_ctrl;
  logic                    res_valid;
  logic                    res_ready;

  modport master (output res_data, output res_ctrl, output res_valid, input res_ready);
  modport slave  (input res_data, input res_ctrl, input res_valid, output res_ready);

endinterface

// File: rtl/systolic_stream_port_stream_beat_mux.sv
// rtl/systolic_stream_port_stream_beat_mux.sv - per-channel beat selector over a buffered block
module stream_beat_mux #(
  parameter int DW    = 4,
  parameter int DEPTH = 16
) (
  input  logic [DEPTH*DW-1:0]        data,
  input  logic [DEPTH-1:0]           ctrl,
  input  logic [$clog2(DEPTH)-1:0]   sel,
  output logic [DW-1:0]              q,
  output logic                       qc
);

  localparam int BW = $clog2(DEPTH);

  always_comb begin
    q  = '0;
    qc = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel == BW'(k)) begin
        q  = data[k*DW +: DW];
        qc = ctrl[k];
      end
    end
  end

endmodule

// File: rtl/systolic_stream_port.sv
// rtl/systolic_stream_port.sv - block-buffered stream port forwarding or substituting core results
module systolic_stream_port
  import systolic_stream_port_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      cap_en,
  input  logic [NCH*DW-1:0]         din,
  input  logic [NCH-1:0]            cin,
  output logic [NCH*DW-1:0]         dout,
  output logic [NCH-1:0]            cout,
  output logic [$clog2(DEPTH)-1:0]  beat,
  output logic                      blk_valid,
  output logic [NCH*DEPTH*DW-1:0]   blk_data,
  output logic [NCH*DEPTH-1:0]      blk_ctrl,
  output logic                      blk_cap,
  systolic_stream_port_if.slave     res
);

  localparam int BW     = $clog2(DEPTH);
  localparam int BLK_DW = NCH * DEPTH * DW;
  localparam int BLK_CW = NCH * DEPTH;
  localparam logic [BW-1:0] LAST_BEAT = BW'(DEPTH - 1);

  logic [BLK_DW-1:0] in_data, out_data, commit_data, rr_data;
  logic [BLK_CW-1:0] in_ctrl, out_ctrl, commit_ctrl, rr_ctrl;
  logic              rr_full;
  logic              last, commit, cap_blk;

  assign last          = (beat == LAST_BEAT);
  assign commit        = en && last;
  assign cap_blk       = cap_en && in_ctrl[blk_off(0, 0, DEPTH, 1)];
  assign res.res_ready = !rr_full;

  // The final beat is still on din/cin at the commit edge, so splice it in.
  always_comb begin
    commit_data = in_data;
    commit_ctrl = in_ctrl;
    for (int c = 0; c < NCH; c++) begin
      commit_data[blk_off(c, DEPTH-1, DEPTH, DW) +: DW] = din[c*DW +: DW];
      commit_ctrl[blk_off(c, DEPTH-1, DEPTH, 1)]        = cin[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      in_data   <= '0;
      in_ctrl   <= '0;
      out_data  <= '0;
      out_ctrl  <= '0;
      blk_data  <= '0;
      blk_ctrl  <= '0;
      blk_valid <= 1'b0;
      blk_cap   <= 1'b0;
    end else if (en) begin
      beat      <= beat + 1'b1;
      blk_valid <= last;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (beat == BW'(k)) begin
            in_data[blk_off(c, k, DEPTH, DW) +: DW] <= din[c*DW +: DW];
            in_ctrl[blk_off(c, k, DEPTH, 1)]        <= cin[c];
          end
        end
      end
      if (last) begin
        blk_data <= commit_data;
        blk_ctrl <= commit_ctrl;
        blk_cap  <= cap_blk;
        if (!cap_blk) begin
          out_data <= commit_data;
          out_ctrl <= commit_ctrl;
        end else if (rr_full) begin
          out_data <= rr_data;
          out_ctrl <= rr_ctrl;
        end else begin
          out_data <= '0;
          out_ctrl <= '0;
        end
      end
    end else begin
      blk_valid <= 1'b0;
    end
  end

  // Accept only into an empty register, so an arrival never feeds the commit on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_full <= 1'b0;
      rr_data <= '0;
      rr_ctrl <= '0;
    end else if (res.res_valid && !rr_full) begin
      rr_full <= 1'b1;
      rr_data <= res.res_data;
      rr_ctrl <= res.res_ctrl;
    end else if (commit && cap_blk && rr_full) begin
      rr_full <= 1'b0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    stream_beat_mux #(.DW(DW), .DEPTH(DEPTH)) u_mux (
      .data (out_data[c*DEPTH*DW +: DEPTH*DW]),
      .ctrl (out_ctrl[c*DEPTH +: DEPTH]),
      .sel  (beat),
      .q    (dout[c*DW +: DW]),
      .qc   (cout[c])
    );
  end

endmodule

// File: tb/tb_systolic_stream_port.sv
// tb/tb_systolic_stream_port.sv - scoreboard bench for systolic_stream_port
module tb_systolic_stream_port;

  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int NCH   = 2;
  localparam int BW    = 4;
  localparam int EW    = NCH*DW + NCH;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic                    cap_en = 1'b0;
  logic [NCH*DW-1:0]       din = '0;
  logic [NCH-1:0]          cin = '0;
  logic [NCH*DW-1:0]       dout;
  logic [NCH-1:0]          cout;
  logic [BW-1:0]           beat;
  logic                    blk_valid;
  logic [NCH*DEPTH*DW-1:0] blk_data;
  logic [NCH*DEPTH-1:0]    blk_ctrl;
  logic                    blk_cap;

  systolic_stream_port_if #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH)) res_if ();

  systolic_stream_port #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cap_en    (cap_en),
    .din       (din),
    .cin       (cin),
    .dout      (dout),
    .cout      (cout),
    .beat      (beat),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ctrl  (blk_ctrl),
    .blk_cap   (blk_cap),
    .res       (res_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0]           sb_q[$];
  bit                      pend;
  logic [NCH*DEPTH*DW-1:0] r_d;
  logic [NCH*DEPTH-1:0]    r_c;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_zero_block();
    for (int k = 0; k < DEPTH; k++) sb_q.push_back('0);
  endtask

  // Drives one block; kind of the next block's output is decided at the commit edge.
  task automatic send_block(input int pat, input bit cap_mode, input bit cflag, input int res_at,
                            input logic [DW-1:0] res_val, input int stall_at, input int rst_at);
    logic [NCH*DEPTH*DW-1:0] bd;
    logic [NCH*DEPTH-1:0]    bc;
    logic [NCH*DW-1:0]       d;
    logic [NCH-1:0]          c;
    logic [EW-1:0]           cur;
    logic [EW-1:0]           e;
    bit                      pb;
    bit                      is_cap;
    int                      kind;
    cap_en = cap_mode;
    pb = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (pat == 0) d[ch*DW +: DW] = (ch == 0) ? DW'(k) : DW'(DEPTH-1-k);
        else          d[ch*DW +: DW] = DW'($urandom);
      end
      c = NCH'($urandom);
      if (k == 0) c[0] = cflag;
      for (int ch = 0; ch < NCH; ch++) begin
        bd[(ch*DEPTH+k)*DW +: DW] = d[ch*DW +: DW];
        bc[ch*DEPTH+k] = c[ch];
      end
      din = d;
      cin = c;
      en  = 1'b1;
      chk("sb_level", sb_q.size(), DEPTH - k);
      cur = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      chk("beat", beat, k);
      chk("dout_cout", {dout, cout}, cur);
      chk("res_ready", res_if.res_ready, !pend);
      if (k == stall_at) begin
        en = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall_beat", beat, k);
          chk("stall_dout", {dout, cout}, cur);
          chk("stall_valid", blk_valid, 0);
        end
        en = 1'b1;
      end
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", {dout, cout}, 0);
        chk("rst_beat", beat, 0);
        chk("rst_valid", blk_valid, 0);
        chk("rst_blk_data", blk_data, 0);
        chk("rst_blk_cap", blk_cap, 0);
        chk("rst_res_ready", res_if.res_ready, 1);
        res_if.res_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        push_zero_block();
        pend = 1'b0;
        return;
      end
      res_if.res_valid = (k == res_at);
      if (k == res_at) begin
        res_if.res_data = {(NCH*DEPTH){res_val}};
        res_if.res_ctrl = $urandom;
      end
      pb = pend;
      @(posedge clk); #1;
      res_if.res_valid = 1'b0;
      if (k == res_at && !pb) begin
        pend = 1'b1;
        r_d  = res_if.res_data;
        r_c  = res_if.res_ctrl;
      end
      chk("blk_valid", blk_valid, k == DEPTH-1);
    end
    is_cap = cap_mode && cflag;
    kind = !is_cap ? 0 : (pb ? 2 : 1);
    if (is_cap && pb) pend = 1'b0;
    chk("blk_cap", blk_cap, is_cap);
    chk("blk_data", blk_data, bd);
    chk("blk_ctrl", blk_ctrl, bc);
    for (int k = 0; k < DEPTH; k++) begin
      e = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (kind == 0) begin
          e[NCH + ch*DW +: DW] = bd[(ch*DEPTH+k)*DW +: DW];
          e[ch] = bc[ch*DEPTH+k];
        end else if (kind == 2) begin
          e[NCH + ch*DW +: DW] = r_d[(ch*DEPTH+k)*DW +: DW];
          e[ch] = r_c[ch*DEPTH+k];
        end
      end
      sb_q.push_back(e);
    end
  endtask

  initial begin
    res_if.res_valid = 1'b0;
    res_if.res_data  = '0;
    res_if.res_ctrl  = '0;
    pend = 1'b0;
    r_d = '0;
    r_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", {dout, cout}, 0);
    chk("reset_beat", beat, 0);
    chk("reset_res_ready", res_if.res_ready, 1);
    chk("reset_valid", blk_valid, 0);
    rst_n = 1'b1;
    push_zero_block();

    send_block(0, 1'b0, 1'b0, -1, 4'h0, -1, -1);
    send_block(1, 1'b0, 1'b1, -1, 4'h0, -1, -1);
    send_block(1, 1'b1, 1'b1, -1, 4'h0, -1, -1);
    send_block(1, 1'b1, 1'b0,  3, 4'hA, -1, -1);
    send_block(1, 1'b1, 1'b1, -1, 4'h0, -1, -1);
    send_block(1, 1'b1, 1'b1, DEPTH-1, 4'h5, -1, -1);
    send_block(1, 1'b0, 1'b0, -1, 4'h0,  7, -1);
    send_block(1, 1'b1, 1'b1, -1, 4'h0, -1, -1);
    send_block(1, 1'b0, 1'b0,  2, 4'h3, -1,  9);
    send_block(1, 1'b0, 1'b0, -1, 4'h0, -1, -1);
    send_block(1, 1'b0, 1'b0, -1, 4'h0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_stream_port.md
SYSTOLIC_STREAM_PORT -- requirements
Module: systolic_stream_port

Interface
REQ-001 SHALL have parameter DW, default 4: beat data width per channel.
REQ-002 SHALL have parameter DEPTH, default 16: beats per block; power of two, at least 2.
REQ-003 SHALL have parameter NCH, default 2: channel count (col, row, ...).
REQ-004 SHALL have derived localparam BW = log2(DEPTH).
REQ-005 SHALL have port clk, input, 1: the only clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1: advance enable; low freezes all state.
REQ-008 SHALL have port cap_en, input, 1: capture mode enable.
REQ-009 SHALL have port din, input, NCH*DW: incoming beat; channel c occupies bits [c*DW +: DW].
REQ-010 SHALL have port cin, input, NCH: incoming control bit per channel.
REQ-011 SHALL have port dout, output, NCH*DW: outgoing beat.
REQ-012 SHALL have port cout, output, NCH: outgoing control bit per channel.
REQ-013 SHALL have port beat, output, BW: current beat index.
REQ-014 SHALL have port blk_valid, output, 1: one-cycle pulse when a completed block is presented.
REQ-015 SHALL have port blk_data, output, NCH*DEPTH*DW: last completed block; beat k of channel c at [(c*DEPTH+k)*DW +: DW].
REQ-016 SHALL have port blk_ctrl, output, NCH*DEPTH: last completed block control bits; same ordering as blk_data.
REQ-017 SHALL have port blk_cap, output, 1: the block on blk_data was captured rather than forwarded.
REQ-018 SHALL have ports res_data (input, NCH*DEPTH*DW), res_ctrl (input, NCH*DEPTH), res_valid (input, 1) and res_ready (output, 1): result block from the compute core.

Function
REQ-019 beat SHALL increment by 1 on each clk edge with en=1 and wrap from DEPTH-1 to 0; a cycle with beat=DEPTH-1 is the last beat.
REQ-020 On each enabled edge, din/cin SHALL be written to in_buf at index beat, for every channel.
REQ-021 On the enabled edge of the last beat, the block SHALL be committed: in_buf[0..DEPTH-2] plus the current din/cin copied to blk_data/blk_ctrl, and blk_valid registered high for exactly the next cycle.
REQ-022 A committed block SHALL be a capture block when cap_en=1 and its beat-0 cin[0]=1; blk_cap is registered with blk_valid and holds until the next commit.
REQ-023 At commit of a non-capture block, out_buf SHALL load the committed block; forwarded-data latency is therefore exactly DEPTH enabled cycles, beat for beat.
REQ-024 At commit of a capture block, out_buf SHALL load the result register if it is full, which then empties; otherwise out_buf SHALL load all zeros.
REQ-025 dout/cout SHALL equal out_buf[beat] for every channel: a mux over registered state only.
REQ-026 The result register SHALL hold one entry; res_ready=1 exactly when it is empty.
REQ-027 When res_valid=1 and res_ready=1, res_data/res_ctrl SHALL be captured on the clk edge regardless of en.
REQ-028 If a result is accepted on the same edge as a capture commit, that result SHALL NOT be used for the current block; it is held for the next capture commit.
REQ-029 When a result is pending while non-capture blocks commit, it SHALL be retained; no data is dropped.
REQ-030 With en=0, beat, in_buf, out_buf and blk_* SHALL be held, and blk_valid forced to 0.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear beat, in_buf, out_buf, blk_data, blk_ctrl, blk_valid, blk_cap and the result register.
REQ-032 After reset, dout=0, cout=0, res_ready=1 and beat=0.
REQ-033 Reset mid-block SHALL discard the partial block; the first block after release starts at beat 0.

Structure
REQ-034 A shared package SHALL hold the default DW/DEPTH/NCH constants and the block-indexing helper (channel/beat to bit offset).
REQ-035 A single sub-module, stream_beat_mux (DW, DEPTH parameters, one per channel), SHALL implement the out_buf[beat] selection.

Verification
REQ-036 Forward: cap_en=0, DW=4, DEPTH=16, NCH=2, ch0 beats 0x0..0xF, ch1 0xF..0x0 -> same sequence on dout 16 cycles later; blk_valid pulses once per 16 cycles; blk_cap=0.
REQ-037 Capture without result: cap_en=1, beat-0 cin[0]=1 -> following block dout=0 and cout=0 for 16 beats; blk_cap=1; blk_data equals the input block.
REQ-038 Capture with result: result accepted (res_data all 0xA) before commit -> next block dout=0xA for all beats; res_ready returns to 1 after commit.
REQ-039 Result racing commit: res_valid at the last-beat edge of a capture block -> that block outputs zeros, the result is emitted on the next capture, res_ready=0 meanwhile.
REQ-040 Stall: en=0 for 5 cycles at beat 7 -> beat stays 7, dout constant, no blk_valid; the stream resumes unchanged.
REQ-041 Reset at beat 9 -> all outputs 0 immediately (asynchronous); the next block aligns to beat 0.
